blake2_round_ctrl: RTL and testbench

Sequencing controller for the BLAKE2 compression rounds. It owns the 16-word working vector v[0..15] and the 16-word message block m[0..15]. It time-multiplexes a single `G` mixing instance, issuing one G call per cycle: 8 calls per round, R rounds. It sits between the block-level hash controller (which initialises v and supplies m) and the finalisation stage (which XORs v into h). Start and result exchanges use valid/ready handshakes.

---
 rtl/blake2_round_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_blake2_round_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blake2_round_ctrl.sv
// blake2_round_ctrl
//   Runs the BLAKE2 compression rounds over a 16-word working vector v,
//   using a single G mixing function that is reused once per cycle:
//   8 G calls per round, R rounds. v is loaded and m is latched on start.
//   The final v is presented until the consumer takes it.
//
// Handshakes (both exchanges): a transfer happens on a rising clk_i edge
//   where valid and ready are both high. Valid never waits on ready. The
//   initiator keeps its payload stable until the transfer happens.
//
// Ports
//   clk_i          clock, all state changes on the rising edge
//   rst_i          synchronous active-high reset
//   start_valid_i  v_i/m_i valid, request to run
//   start_ready_o  controller idle, start can be accepted
//   v_i, m_i       initial v and message block, word j at [j*W +: W]
//   res_valid_o    v_o holds the final v
//   res_ready_i    consumer accepts the result
//   v_o            working vector register, same packing as v_i
//   round_o        current round index (debug)
//   busy_o         high while rounds are running
module blake2_round_ctrl #(
  parameter int W  = 64,
  parameter int R  = 12,
  parameter int R1 = 32,
  parameter int R2 = 24,
  parameter int R3 = 16,
  parameter int R4 = 63
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_valid_i,
  output logic            start_ready_o,
  input  logic [16*W-1:0] v_i,
  input  logic [16*W-1:0] m_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [16*W-1:0] v_o,
  output logic [3:0]      round_o,
  output logic            busy_o
);

  // The round counter is 4 bits wide. Only R in 1..15 fits that counter.
  generate
    if (R < 1 || R > 15) begin : g_bad_rounds
      $fatal(1, "blake2_round_ctrl: R must be in 1..15");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [3:0] LAST_ROUND = 4'(R - 1);

  state_t       state_q, state_d;
  logic [W-1:0] v_q [16];
  logic [W-1:0] m_q [16];
  logic [3:0]   round_q;
  logic [2:0]   g_q;
  logic         last_call;

  assign last_call = (g_q == 3'd7) && (round_q == LAST_ROUND);

  // ---------------- FSM ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    start_ready_o = 1'b0;
    res_valid_o   = 1'b0;
    busy_o        = 1'b0;
    case (state_q)
      IDLE: begin
        start_ready_o = 1'b1;
        if (start_valid_i) state_d = RUN;
      end
      RUN: begin
        busy_o = 1'b1;
        if (last_call) state_d = DONE;
      end
      DONE: begin
        res_valid_o = 1'b1;
        if (res_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- G call schedule ----------------
  logic [3:0] a_idx, b_idx, c_idx, d_idx;

  always_comb begin
    a_idx = 4'd0; b_idx = 4'd4; c_idx = 4'd8; d_idx = 4'd12;
    case (g_q)
      3'd0: begin a_idx = 4'd0; b_idx = 4'd4; c_idx = 4'd8;  d_idx = 4'd12; end
      3'd1: begin a_idx = 4'd1; b_idx = 4'd5; c_idx = 4'd9;  d_idx = 4'd13; end
      3'd2: begin a_idx = 4'd2; b_idx = 4'd6; c_idx = 4'd10; d_idx = 4'd14; end
      3'd3: begin a_idx = 4'd3; b_idx = 4'd7; c_idx = 4'd11; d_idx = 4'd15; end
      3'd4: begin a_idx = 4'd0; b_idx = 4'd5; c_idx = 4'd10; d_idx = 4'd15; end
      3'd5: begin a_idx = 4'd1; b_idx = 4'd6; c_idx = 4'd11; d_idx = 4'd12; end
      3'd6: begin a_idx = 4'd2; b_idx = 4'd7; c_idx = 4'd8;  d_idx = 4'd13; end
      default: begin a_idx = 4'd3; b_idx = 4'd4; c_idx = 4'd9; d_idx = 4'd14; end
    endcase
  end

  // Message schedule ROM. Each row packs sigma[s][0] into the top nibble,
  // so the index pair for call g sits in byte (7-g) of the row.
  function automatic logic [63:0] sigma_row(input logic [3:0] s);
    case (s)
      4'd0:    return 64'h0123456789ABCDEF;
      4'd1:    return 64'hEA489FD61C02B753;
      4'd2:    return 64'hB8C052FDAE367194;
      4'd3:    return 64'h7931DCBE265A40F8;
      4'd4:    return 64'h905724AFE1BC683D;
      4'd5:    return 64'h2C6A0B834D75FE19;
      4'd6:    return 64'hC51FED4A0763928B;
      4'd7:    return 64'hDB7EC13950F4862A;
      4'd8:    return 64'h6FE9B308C2D714A5;
      4'd9:    return 64'hA2847615FB9E3CD0;
      default: return 64'h0123456789ABCDEF;
    endcase
  endfunction

  logic [3:0]  sig_sel;
  logic [63:0] sig_row;
  logic [7:0]  sig_pair;

  // Rounds 10..14 wrap back onto rows 0..4 (round mod 10).
  assign sig_sel  = (round_q >= 4'd10) ? (round_q - 4'd10) : round_q;
  assign sig_row  = sigma_row(sig_sel);
  assign sig_pair = 8'(sig_row >> {~g_q, 3'b000});

  // ---------------- G (single combinational instance) ----------------
  function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input int n);
    return (x >> n) | (x << (W - n));
  endfunction

  logic [W-1:0] g_x, g_y, a1, b1, c1, d1, a2, b2, c2, d2;

  always_comb begin
    g_x = m_q[sig_pair[7:4]];
    g_y = m_q[sig_pair[3:0]];
    a1  = v_q[a_idx] + v_q[b_idx] + g_x;
    d1  = rotr(v_q[d_idx] ^ a1, R1);
    c1  = v_q[c_idx] + d1;
    b1  = rotr(v_q[b_idx] ^ c1, R2);
    a2  = a1 + b1 + g_y;
    d2  = rotr(d1 ^ a2, R3);
    c2  = c1 + d2;
    b2  = rotr(b1 ^ c2, R4);
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int j = 0; j < 16; j++) begin
        v_q[j] <= '0;
        m_q[j] <= '0;
      end
      round_q <= 4'd0;
      g_q     <= 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid_i) begin
            for (int j = 0; j < 16; j++) begin
              v_q[j] <= v_i[j*W +: W];
              m_q[j] <= m_i[j*W +: W];
            end
            round_q <= 4'd0;
            g_q     <= 3'd0;
          end
        end
        RUN: begin
          v_q[a_idx] <= a2;
          v_q[b_idx] <= b2;
          v_q[c_idx] <= c2;
          v_q[d_idx] <= d2;
          g_q        <= g_q + 3'd1;
          // The round index stays at R-1 after the last call.
          if (g_q == 3'd7 && round_q != LAST_ROUND) round_q <= round_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

  generate
    for (genvar j = 0; j < 16; j++) begin : g_pack
      assign v_o[j*W +: W] = v_q[j];
    end
  endgenerate

  assign round_o = round_q;

endmodule

// File: tb/tb_blake2_round_ctrl.sv
// Testbench for blake2_round_ctrl. Two instances: BLAKE2b (W=64, R=12) and
// BLAKE2s (W=32, R=10). It has a software round model and the RFC 7693 "abc"
// digests. A scoreboard queue holds the expected final v for each accepted
// BLAKE2b block.
module tb_blake2_round_ctrl;

  localparam int W  = 64;
  localparam int R  = 12;
  localparam int WS = 32;
  localparam int RS = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT signals ----------------
  logic            start_valid, start_ready, res_valid, res_ready, busy;
  logic [16*W-1:0] v_in, m_in, v_out;
  logic [3:0]      round;

  logic             s_start_valid, s_start_ready, s_res_valid, s_res_ready, s_busy;
  logic [16*WS-1:0] s_v_in, s_m_in, s_v_out;
  logic [3:0]       s_round;

  blake2_round_ctrl #(.W(W), .R(R), .R1(32), .R2(24), .R3(16), .R4(63)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_valid_i(start_valid), .start_ready_o(start_ready),
    .v_i(v_in), .m_i(m_in), .res_valid_o(res_valid), .res_ready_i(res_ready),
    .v_o(v_out), .round_o(round), .busy_o(busy)
  );

  blake2_round_ctrl #(.W(WS), .R(RS), .R1(16), .R2(12), .R3(8), .R4(7)) dut_s (
    .clk_i(clk), .rst_i(rst), .start_valid_i(s_start_valid), .start_ready_o(s_start_ready),
    .v_i(s_v_in), .m_i(s_m_in), .res_valid_o(s_res_valid), .res_ready_i(s_res_ready),
    .v_o(s_v_out), .round_o(s_round), .busy_o(s_busy)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // ---------------- software reference model ----------------
  int sigma_t [10][16] = '{
    '{ 0,  1,  2,  3,  4,  5,  6,  7,  8,  9, 10, 11, 12, 13, 14, 15},
    '{14, 10,  4,  8,  9, 15, 13,  6,  1, 12,  0,  2, 11,  7,  5,  3},
    '{11,  8, 12,  0,  5,  2, 15, 13, 10, 14,  3,  6,  7,  1,  9,  4},
    '{ 7,  9,  3,  1, 13, 12, 11, 14,  2,  6,  5, 10,  4,  0, 15,  8},
    '{ 9,  0,  5,  7,  2,  4, 10, 15, 14,  1, 11, 12,  6,  8,  3, 13},
    '{ 2, 12,  6, 10,  0, 11,  8,  3,  4, 13,  7,  5, 15, 14,  1,  9},
    '{12,  5,  1, 15, 14, 13,  4, 10,  0,  7,  6,  3,  9,  2,  8, 11},
    '{13, 11,  7, 14, 12,  1,  3,  9,  5,  0, 15,  4,  8,  6,  2, 10},
    '{ 6, 15, 14,  9, 11,  3,  0,  8, 12,  2, 13,  7,  1,  4, 10,  5},
    '{10,  2,  8,  4,  7,  6,  1,  5, 15, 11,  9, 14,  3, 12, 13,  0}
  };
  int ga [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int gb [8] = '{4, 5, 6, 7, 5, 6, 7, 4};
  int gc [8] = '{8, 9, 10, 11, 10, 11, 8, 9};
  int gd [8] = '{12, 13, 14, 15, 15, 12, 13, 14};

  function automatic logic [63:0] m_rotr(input logic [63:0] x, input int n, input int w,
                                         input logic [63:0] mask);
    return ((x >> n) | (x << (w - n))) & mask;
  endfunction

  function automatic logic [1023:0] blake_model(input logic [1023:0] vin, input logic [1023:0] min,
                                                input int w, input int nr, input int r1,
                                                input int r2, input int r3, input int r4);
    logic [63:0]   v [16];
    logic [63:0]   m [16];
    logic [63:0]   mask, a, b, c, d, x, y;
    logic [1023:0] o;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    for (int j = 0; j < 16; j++) begin
      v[j] = vin[j*w +: 64] & mask;
      m[j] = min[j*w +: 64] & mask;
    end
    for (int r = 0; r < nr; r++) begin
      for (int g = 0; g < 8; g++) begin
        a = v[ga[g]]; b = v[gb[g]]; c = v[gc[g]]; d = v[gd[g]];
        x = m[sigma_t[r % 10][2*g]];
        y = m[sigma_t[r % 10][2*g+1]];
        a = (a + b + x) & mask;  d = m_rotr(d ^ a, r1, w, mask);
        c = (c + d) & mask;      b = m_rotr(b ^ c, r2, w, mask);
        a = (a + b + y) & mask;  d = m_rotr(d ^ a, r3, w, mask);
        c = (c + d) & mask;      b = m_rotr(b ^ c, r4, w, mask);
        v[ga[g]] = a; v[gb[g]] = b; v[gc[g]] = c; v[gd[g]] = d;
      end
    end
    o = '0;
    for (int j = 0; j < 16; j++) o = o | (1024'(v[j]) << (j * w));
    return o;
  endfunction

  // ---------------- scoreboard ----------------
  logic [1023:0] exp_q [$];
  int            lat_q [$];

  // Monitor: round stepping, latency, busy length and result comparison.
  int busy_cnt = 0;
  bit prev_valid = 1'b0;
  always @(negedge clk) begin
    logic [1023:0] e;
    int            st;
    if (rst) begin
      busy_cnt   = 0;
      prev_valid = 1'b0;
    end else begin
      if (busy) begin
        check("round_step", 64'(round), 64'(busy_cnt / 8));
        busy_cnt++;
      end
      if (res_valid && !prev_valid) begin
        if (lat_q.size() == 0) check("spurious_res_valid", 64'(res_valid), 64'd0);
        else begin
          st = lat_q.pop_front();
          check("latency", 64'(cyc - st), 64'(8 * R));
          check("busy_cycles", 64'(busy_cnt), 64'(8 * R));
        end
        busy_cnt = 0;
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) check("res_unexpected", 64'(res_valid), 64'd0);
        else begin
          e = exp_q.pop_front();
          for (int j = 0; j < 16; j++) check($sformatf("v_word%0d", j), v_out[j*64 +: 64], e[j*64 +: 64]);
        end
      end
      prev_valid = res_valid;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [1023:0] rand1024();
    logic [1023:0] r;
    for (int j = 0; j < 32; j++) r[j*32 +: 32] = $urandom;
    return r;
  endfunction

  // Called one step after a rising edge.
  task automatic send(input logic [1023:0] v, input logic [1023:0] m);
    bit ok = 1'b0;
    start_valid = 1'b1; v_in = v; m_in = m;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (start_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("start_timeout", 64'(start_ready), 64'd1);
    @(posedge clk); #1;
    start_valid = 1'b0;
    v_in = rand1024(); m_in = rand1024();
    if (ok) begin
      exp_q.push_back(blake_model(v, m, 64, 12, 32, 24, 16, 63));
      lat_q.push_back(cyc);
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (res_valid) begin ok = 1'b1; break; end
    end
    if (!ok) check("res_timeout", 64'(res_valid), 64'd1);
  endtask

  task automatic finish_result(input int stall);
    @(posedge clk); #1;
    repeat (stall) begin @(posedge clk); #1; end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  // ---------------- known-answer vectors ----------------
  logic [63:0] b_iv [8] = '{64'h6A09E667F3BCC908, 64'hBB67AE8584CAA73B, 64'h3C6EF372FE94F82B,
                            64'hA54FF53A5F1D36F1, 64'h510E527FADE682D1, 64'h9B05688C2B3E6C1F,
                            64'h1F83D9ABFB41BD6B, 64'h5BE0CD19137E2179};
  logic [63:0] b_dig [8] = '{64'h0D4D1C983FA580BA, 64'hE9F6129FB697276A, 64'hB7C45A68142F214C,
                             64'hD1A2FFDB6FBB124B, 64'h2D79AB2A39C5877D, 64'h95CC3345DED552C2,
                             64'h5A92F1DBA88AD318, 64'h239900D4ED8623B9};
  logic [31:0] s_iv [8] = '{32'h6A09E667, 32'hBB67AE85, 32'h3C6EF372, 32'hA54FF53A,
                            32'h510E527F, 32'h9B05688C, 32'h1F83D9AB, 32'h5BE0CD19};
  logic [31:0] s_dig [8] = '{32'h8C5E8C50, 32'hE2147C32, 32'hA32BA7E1, 32'h2F45EB4E,
                             32'h208B4537, 32'h293AD69E, 32'h4C9B994D, 32'h82596786};

  // ---------------- main sequence ----------------
  initial begin
    logic [1023:0] bv, bm, se;
    logic [63:0]   h [8];
    logic [31:0]   hs [8];
    bit            ok;
    int            j_edge, cnt, st;

    rst = 1'b1; start_valid = 1'b0; res_ready = 1'b0; v_in = '0; m_in = '0;
    s_start_valid = 1'b0; s_res_ready = 1'b0; s_v_in = '0; s_m_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_start_ready", 64'(start_ready), 64'd1);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_round", 64'(round), 64'd0);
    check("rst_v_zero", 64'(|v_out), 64'd0);
    rst = 1'b0;

    // Zero block.
    repeat (6) begin @(posedge clk); #1; end
    send('0, '0);
    wait_valid(ok);
    finish_result(2);

    // BLAKE2b "abc", final block.
    bv = '0; bm = '0;
    for (int i = 0; i < 8; i++) h[i] = b_iv[i];
    h[0] = h[0] ^ 64'h0000_0000_0101_0040;
    for (int i = 0; i < 8; i++) begin
      bv[i*64 +: 64]     = h[i];
      bv[(i+8)*64 +: 64] = b_iv[i];
    end
    bv[12*64 +: 64] = b_iv[4] ^ 64'd3;
    bv[14*64 +: 64] = ~b_iv[6];
    bm[63:0] = 64'h0000_0000_0063_6261;
    send(bv, bm);
    wait_valid(ok);
    for (int i = 0; i < 8; i++)
      check($sformatf("b_digest%0d", i), h[i] ^ v_out[i*64 +: 64] ^ v_out[(i+8)*64 +: 64], b_dig[i]);

    // Backpressure on the abc result: v held, start ignored.
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      start_valid = i[0]; v_in = rand1024(); m_in = rand1024();
      @(negedge clk);
      check("bp_v_stable", 64'(v_out == exp_q[0]), 64'd1);
      check("bp_start_ready", 64'(start_ready), 64'd0);
      check("bp_res_valid", 64'(res_valid), 64'd1);
    end
    @(posedge clk); #1;
    start_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    j_edge = cyc;
    check("bp_release_ready", 64'(start_ready), 64'd1);
    send(rand1024(), rand1024());
    check("bp_accept_edge", 64'(lat_q[$]), 64'(j_edge + 1));
    wait_valid(ok);
    finish_result(1);

    // Reset in the middle of a run.
    send(rand1024(), rand1024());
    repeat (39) begin @(posedge clk); #1; end
    exp_q.delete(); lat_q.delete();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_ready", 64'(start_ready), 64'd1);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_round", 64'(round), 64'd0);
    check("mid_rst_v_zero", 64'(|v_out), 64'd0);
    cnt = 0;
    for (int i = 0; i < 110; i++) begin
      @(negedge clk);
      if (res_valid) cnt++;
    end
    check("mid_rst_no_result", 64'(cnt), 64'd0);
    @(posedge clk); #1;
    send(rand1024(), rand1024());
    wait_valid(ok);
    finish_result(0);

    // BLAKE2s "abc".
    s_v_in = '0; s_m_in = '0;
    for (int i = 0; i < 8; i++) hs[i] = s_iv[i];
    hs[0] = hs[0] ^ 32'h0101_0020;
    for (int i = 0; i < 8; i++) begin
      s_v_in[i*32 +: 32]     = hs[i];
      s_v_in[(i+8)*32 +: 32] = s_iv[i];
    end
    s_v_in[12*32 +: 32] = s_iv[4] ^ 32'd3;
    s_v_in[14*32 +: 32] = ~s_iv[6];
    s_m_in[31:0] = 32'h0063_6261;
    se = blake_model({512'd0, s_v_in}, {512'd0, s_m_in}, 32, 10, 16, 12, 8, 7);
    s_start_valid = 1'b1;
    @(negedge clk);
    check("s_start_ready", 64'(s_start_ready), 64'd1);
    @(posedge clk); #1;
    s_start_valid = 1'b0;
    st = cyc; cnt = 0; ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (s_busy) cnt++;
      if (s_res_valid) begin ok = 1'b1; break; end
    end
    check("s_res_seen", 64'(ok), 64'd1);
    check("s_latency", 64'(cyc - st), 64'(8 * RS));
    check("s_busy_cycles", 64'(cnt), 64'(8 * RS));
    for (int j = 0; j < 16; j++) check($sformatf("s_v_word%0d", j), 64'(s_v_out[j*32 +: 32]), 64'(se[j*32 +: 32]));
    for (int i = 0; i < 8; i++)
      check($sformatf("s_digest%0d", i), 64'(hs[i] ^ s_v_out[i*32 +: 32] ^ s_v_out[(i+8)*32 +: 32]), 64'(s_dig[i]));
    @(posedge clk); #1;
    s_res_ready = 1'b1;
    @(posedge clk); #1;
    s_res_ready = 1'b0;
    check("s_back_idle", 64'(s_start_ready), 64'd1);

    // Randomised blocks with random result stalls.
    for (int n = 0; n < 40; n++) begin
      send(rand1024(), rand1024());
      wait_valid(ok);
      finish_result($urandom_range(0, 6));
    end

    repeat (3) begin @(posedge clk); #1; end
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("lat_queue_empty", 64'(lat_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
